// File: rtl/digit_scan_demux.sv
`timescale 1ns/1ps
// digit_scan_demux: scans an upstream N-way mux by driving its select index,
// waits SETTLE cycles for the mux output to settle, then samples it into the
// matching slot of a parallel SLOTS*WIDTH output word.
//
// Optional build macro: DIGIT_SCAN_DOUBLE_BUFFER_EN
//   defined     - samples land in a shadow word; dout loads the whole frame
//                 atomically on the edge entering DONE.
//   not defined - each dout slot updates as soon as it is sampled.
module digit_scan_demux #(
    parameter int WIDTH  = 3,
    parameter int SLOTS  = 9,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [WIDTH-1:0]         din,
    output logic [SEL_W-1:0]         sel,
    output logic [SLOTS*WIDTH-1:0]   dout,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     valid
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [SEL_W-1:0]         sel_r;
    logic [SLOTS*WIDTH-1:0]   dout_r;
    logic                     busy_r;
    logic                     frame_done_r;
    logic                     valid_r;
    logic [SLOTS*WIDTH-1:0]   base_s;
    logic [SLOTS*WIDTH-1:0]   merged_s;

`ifdef DIGIT_SCAN_DOUBLE_BUFFER_EN
    logic [SLOTS*WIDTH-1:0]   shadow_r;
    assign base_s = shadow_r;
`else
    assign base_s = dout_r;
`endif

    // Word that results from writing the current din into slot sel_r.
    always_comb begin
        merged_s = base_s;
        for (int k = 0; k < SLOTS; k++) begin
            if (sel_r == SEL_W'(k)) begin
                merged_s[k*WIDTH +: WIDTH] = din;
            end else begin
                merged_s[k*WIDTH +: WIDTH] = base_s[k*WIDTH +: WIDTH];
            end
        end
    end

    // Scan sequencer: state, settle counter, select index and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            sel_r        <= {SEL_W{1'b0}};
            dout_r       <= {(SLOTS*WIDTH){1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            valid_r      <= 1'b0;
`ifdef DIGIT_SCAN_DOUBLE_BUFFER_EN
            shadow_r     <= {(SLOTS*WIDTH){1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sel_r        <= {SEL_W{1'b0}};
                    frame_done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_SETTLE;
                        cnt_r   <= CNT_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    frame_done_r <= 1'b0;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
`ifdef DIGIT_SCAN_DOUBLE_BUFFER_EN
                    shadow_r <= merged_s;
`else
                    dout_r   <= merged_s;
`endif
                    if (sel_r == SEL_LAST) begin
                        // Last slot: the frame is complete.
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                        valid_r      <= 1'b1;
`ifdef DIGIT_SCAN_DOUBLE_BUFFER_EN
                        dout_r       <= merged_s;
`endif
                    end else begin
                        sel_r   <= sel_r + SEL_W'(1);
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    frame_done_r <= 1'b0;
                    sel_r        <= {SEL_W{1'b0}};
                    if (continuous) begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_SETTLE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    sel_r        <= {SEL_W{1'b0}};
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_r;
    assign dout       = dout_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign valid      = valid_r;

endmodule

// File: tb/tb_digit_scan_demux.sv
`timescale 1ns/1ps
// Testbench for digit_scan_demux: a default instance (9 slots, SETTLE=1) and
// a small instance (4 slots, SETTLE=3), checked cycle by cycle against a
// schedule computed from the frame timing rules.
module tb_digit_scan_demux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, cont_a;
    logic [2:0]  din_a;
    logic [3:0]  sel_a;
    logic [26:0] dout_a;
    logic        busy_a, fd_a, valid_a;

    logic        start_b, cont_b;
    logic [2:0]  din_b;
    logic [1:0]  sel_b;
    logic [11:0] dout_b;
    logic        busy_b, fd_b, valid_b;

    logic [2:0]  mux_a [0:8];
    logic [2:0]  old_a [0:8];
    logic [2:0]  new_a [0:8];
    logic [2:0]  old_b [0:3];
    logic [2:0]  new_b [0:3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Upstream mux model: output follows the select index.
    always_comb din_a = (sel_a < 4'd9) ? mux_a[sel_a] : 3'd0;

    digit_scan_demux dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a),
        .din(din_a), .sel(sel_a), .dout(dout_a), .busy(busy_a),
        .frame_done(fd_a), .valid(valid_a)
    );

    digit_scan_demux #(.WIDTH(3), .SLOTS(4), .SEL_W(2), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
        .din(din_b), .sel(sel_b), .dout(dout_b), .busy(busy_b),
        .frame_done(fd_b), .valid(valid_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame of instance A, entered on the cycle right after the start edge.
    task automatic frame_a(input bit start_mid, input bit cont_mid);
        logic [26:0] exp_d;
        bit          upd;
        for (int k = 0; k < 9; k++) new_a[k] = mux_a[k];
        for (int c = 0; c <= 18; c++) begin
            for (int k = 0; k < 9; k++) begin
`ifdef DIGIT_SCAN_DOUBLE_BUFFER_EN
                upd = (c == 18);
`else
                upd = (c > 2*k + 1);
`endif
                exp_d[k*3 +: 3] = upd ? new_a[k] : old_a[k];
            end
            chk("a_sel",  sel_a, (c/2 > 8) ? 8 : c/2);
            chk("a_busy", busy_a, 1);
            chk("a_fd",   fd_a, (c == 18));
            chk("a_dout", dout_a, exp_d);
            if (c == 18) chk("a_valid", valid_a, 1);
            start_a = (start_mid && c == 6);
            if (c == 8) cont_a = cont_mid;
            tick();
        end
        start_a = 1'b0;
        for (int k = 0; k < 9; k++) old_a[k] = new_a[k];
    endtask

    // One frame of instance B with din changing every cycle.
    task automatic frame_b();
        logic [11:0] exp_d;
        bit          upd;
        for (int c = 0; c <= 16; c++) begin
            for (int k = 0; k < 4; k++) begin
`ifdef DIGIT_SCAN_DOUBLE_BUFFER_EN
                upd = (c == 16);
`else
                upd = (c > 4*k + 3);
`endif
                exp_d[k*3 +: 3] = upd ? new_b[k] : old_b[k];
            end
            chk("b_sel",  sel_b, (c/4 > 3) ? 3 : c/4);
            chk("b_busy", busy_b, 1);
            chk("b_fd",   fd_b, (c == 16));
            chk("b_dout", dout_b, exp_d);
            din_b = 3'($urandom % 8);
            if ((c % 4) == 3 && c < 16) new_b[c/4] = din_b;
            tick();
        end
        for (int k = 0; k < 4; k++) old_b[k] = new_b[k];
    endtask

    task automatic idle_a(input int n);
        logic [26:0] exp_d;
        for (int k = 0; k < 9; k++) exp_d[k*3 +: 3] = old_a[k];
        for (int i = 0; i < n; i++) begin
            chk("a_idle_busy", busy_a, 0);
            chk("a_idle_fd",   fd_a, 0);
            chk("a_idle_sel",  sel_a, 0);
            chk("a_idle_dout", dout_a, exp_d);
            tick();
        end
    endtask

    initial begin
        logic [26:0] ref_d;
        rst_n = 1'b1; start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
        din_b = 3'd0;
        for (int k = 0; k < 9; k++) begin mux_a[k] = 3'd0; old_a[k] = 3'd0; end
        for (int k = 0; k < 4; k++) begin old_b[k] = 3'd0; new_b[k] = 3'd0; end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel",   sel_a, 0);
        chk("rst_dout",  dout_a, 0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_fd",    fd_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_b_dout", dout_b, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single frame, mux output = sel, slot 8 -> 5.
        for (int k = 0; k < 8; k++) mux_a[k] = 3'(k);
        mux_a[8] = 3'd5;
        idle_a(3);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("a_valid_pre", valid_a, 0);
        frame_a(1'b0, 1'b0);
        chk("a_frame1_dout", dout_a,
            {3'd5, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        chk("a_frame1_valid", valid_a, 1);
        idle_a(4);

        // Continuous: random frame, then inverted-select frame, then drop.
        for (int k = 0; k < 9; k++) mux_a[k] = 3'($urandom % 8);
        cont_a = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        frame_a(1'b0, 1'b1);
        for (int k = 0; k < 9; k++) mux_a[k] = 3'(k) ^ 3'd7;
        frame_a(1'b0, 1'b1);
        for (int k = 0; k < 9; k++) ref_d[k*3 +: 3] = 3'(k) ^ 3'd7;
        chk("a_cont_inv_dout", dout_a, ref_d);
        for (int k = 0; k < 9; k++) mux_a[k] = 3'($urandom % 8);
        frame_a(1'b0, 1'b0);
        idle_a(25);

        // Start pulsed while busy (at sel=3) must not restart the frame.
        for (int k = 0; k < 9; k++) mux_a[k] = 3'($urandom % 8);
        start_a = 1'b1; tick(); start_a = 1'b0;
        frame_a(1'b1, 1'b0);
        idle_a(3);

        // Small instance: SLOTS=4, SETTLE=3, two frames.
        start_b = 1'b1; tick(); start_b = 1'b0;
        frame_b();
        chk("b_idle_busy", busy_b, 0);
        chk("b_valid", valid_b, 1);
        start_b = 1'b1; tick(); start_b = 1'b0;
        frame_b();
        chk("b_idle_busy2", busy_b, 0);

        // Reset in the middle of a frame, at sel=4.
        for (int k = 0; k < 9; k++) mux_a[k] = 3'($urandom % 8);
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("a_pre_rst_sel", sel_a, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel",   sel_a, 0);
        chk("mid_rst_dout",  dout_a, 0);
        chk("mid_rst_busy",  busy_a, 0);
        chk("mid_rst_fd",    fd_a, 0);
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_b_valid", valid_b, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) old_a[k] = 3'd0;
        idle_a(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digit_scan_demux.md
# digit_scan_demux

Scanning demultiplexer: the receiving end of the digit-select multiplexers. It drives the select index to an upstream N-way mux, waits for the mux output to settle, and samples each slot into its own register, rebuilding a parallel SLOTS×WIDTH word from the time-multiplexed stream. It sits between the register-file/display muxes and the consumers that need all digits at once: front-panel latch, debug snapshot.

## Interface
- WIDTH, 3: bits per slot; matches the 3-bit digit muxes.
- SLOTS, 9: number of slots scanned, 2..16.
- SEL_W, 4: Sel width; must satisfy 2^SEL_W >= SLOTS.
- SETTLE, 1: wait cycles after each Sel change before sampling, >= 1.

- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  begins a frame when sampled high in IDLE; ignored otherwise.
- Continuous  in  1  high when DONE is reached: start the next frame immediately; low: return to IDLE.
- Din  in  WIDTH  mux output y for the current Sel.
- Sel  out  SEL_W  select index driven to the upstream mux.
- Dout  out  SLOTS*WIDTH  slot k at Dout[k*WIDTH +: WIDTH].
- Busy  out  1  high in SETTLE, SAMPLE, DONE.
- FrameDone  out  1  one-cycle strobe, high during DONE.
- Valid  out  1  set at first completed frame; cleared only by reset.

## Operation
- All outputs are registered.
- FSM states:
  - IDLE:
    - Sel=0.
    - Start=1 → SETTLE, wait counter loaded with SETTLE-1.
  - SETTLE:
    - counter≠0: decrement, stay.
    - counter=0: → SAMPLE.
  - SAMPLE:
    - capture Din into slot Sel.
    - Sel=SLOTS-1 → DONE.
    - else Sel+1, reload counter, → SETTLE.
  - DONE:
    - FrameDone=1, Valid←1.
    - Continuous=1: Sel←0, reload counter, → SETTLE.
    - else Sel←0, → IDLE.
- Sel never exceeds SLOTS-1; no wrap through unused codes.
- Din is sampled only in SAMPLE; its value in any other state is ignored.
- Start held high in IDLE after DONE restarts a frame; this is intentional.
- Continuous is sampled only in DONE. Dropping it mid-frame finishes the current frame, then returns to IDLE.
- Reset at any time, including mid-frame:
  - state=IDLE.
  - Sel=0, Dout=0, Busy=0, FrameDone=0, Valid=0.
  - counter=0; shadow registers = 0.

## Timing
- Per slot: SETTLE cycles in SETTLE, then 1 cycle in SAMPLE.
- Frame length: SLOTS*(SETTLE+1) cycles, then 1 DONE cycle.
  - Defaults: 18 + 1 = 19 cycles from the first SETTLE cycle to the end of DONE.
- Start sampled at edge t: Busy=1 and Sel=0 visible from t+1.
- With Continuous=1, the next frame's SETTLE follows DONE directly. Period = SLOTS*(SETTLE+1)+1 cycles.
- Sel changes only on the edge leaving SAMPLE, or DONE. It is stable for at least SETTLE+1 cycles before the sampling edge.
- Dout update timing depends on configuration (below).

## Configuration
- DIGIT_SCAN_DOUBLE_BUFFER_EN defined:
  - Samples go to shadow registers.
  - Dout is loaded with the whole shadow word on the edge entering DONE, so Dout changes atomically, coincident with FrameDone rising.
  - Dout is never a mix of two frames.
- Not defined:
  - No shadow registers.
  - Each Dout slot updates on the edge leaving its SAMPLE cycle.
  - Mid-frame, Dout mixes new and old slots.

## Test plan
- Reset mid-frame:
  - Stimulus: Start, then Rst_n=0 at Sel=4.
  - Required: Sel=0, Dout=0, Busy=0, Valid=0, FrameDone=0 immediately, without waiting for a clock edge.
- Single frame, defaults:
  - Stimulus: model the upstream mux as Din=Sel (values 0..7, slot 8 → 3'd5). Pulse Start.
  - Required: FrameDone high exactly 19 cycles after the Start edge plus one; Dout = {5,7,6,5,4,3,2,1,0}; Valid=1; Busy=0 the next cycle.
- Continuous mode:
  - Stimulus: Continuous=1; change Din per slot to Sel^3'b111 between frames.
  - Required: FrameDone strobes every 19 cycles; second-frame Dout slot k = k^7.
  - Stimulus: drop Continuous mid-frame.
  - Required: exactly one more FrameDone, then IDLE.
- Start while busy:
  - Stimulus: pulse Start at Sel=3.
  - Required: no restart; frame completes on schedule.
- SETTLE=3, SLOTS=4:
  - Required: Sel holds each value 4 cycles; FrameDone at cycle 17; sampled values are those present on the 4th cycle of each slot.
- Buffer mode:
  - With DIGIT_SCAN_DOUBLE_BUFFER_EN: Dout is constant through the second frame until DONE.
  - Without it: slot 0 changes at cycle 2 of the second frame.
